// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz extractor path (column generator and accumulator).
// Holds default sizes, the column type and the output-buffer state encoding.
package toeplitz_pkg;

  localparam int unsigned DefaultN = 256;  // columns per block
  localparam int unsigned DefaultL = 128;  // column width = hash width
  localparam int unsigned DefaultBs = DefaultN;  // block size in beats
  localparam int unsigned DefaultCntW = $clog2(DefaultN);

  typedef logic [DefaultL-1:0] col_t;

  typedef enum logic {
    BufEmpty,
    BufFull
  } buf_state_e;

  // Keeps the beat counter at least one bit wide for degenerate N.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toeplitz_accum_if.sv
// Column-stream input and hash output handshakes of the Toeplitz accumulator.
// The master is the producer/sink side; the slave is the accumulator.
interface toeplitz_accum_if
  import toeplitz_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned L = DefaultL
);

  localparam int unsigned CntW = cnt_width(N);

  logic            restart;
  logic            in_valid;
  logic            in_ready;
  logic [L-1:0]    in_col;
  logic            in_bit;
  logic            out_valid;
  logic            out_ready;
  logic [L-1:0]    out_hash;
  logic [CntW-1:0] beat_cnt;

  modport master (
    output restart, in_valid, in_col, in_bit, out_ready,
    input  in_ready, out_valid, out_hash, beat_cnt
  );

  modport slave (
    input  restart, in_valid, in_col, in_bit, out_ready,
    output in_ready, out_valid, out_hash, beat_cnt
  );

endinterface

// File: rtl/toep_out_buf.sv
// Single-entry valid/ready output register for completed hashes.
// A load while draining replaces the entry in the same cycle, so there is no bubble.
module toep_out_buf
  import toeplitz_pkg::*;
#(
  parameter int unsigned L = DefaultL
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [L-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [L-1:0] data_o
);

  buf_state_e   state_q, state_d;
  logic [L-1:0] data_q, data_d;

  // The producer never loads while FULL and not draining, so a held entry is never overwritten.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = BufFull;
      data_d  = data_i;
    end else if ((state_q == BufFull) && ready_i) begin
      state_d = BufEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BufEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == BufFull);
  assign data_o  = data_q;

endmodule

// File: rtl/toeplitz_accum.sv
// Toeplitz hash accumulator: XORs each column whose data bit is 1 and, after N beats,
// hands the L-bit GF(2) product to a single-entry output buffer.
module toeplitz_accum
  import toeplitz_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned L = DefaultL
) (
  input logic              clk,
  input logic              reset,
  toeplitz_accum_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastBeat = CntW'(N - 1);

  logic [L-1:0]    acc_q, acc_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [L-1:0]    term;
  logic            last_beat;
  logic            in_fire;
  logic            final_fire;

  assign last_beat = (beat_cnt_q == LastBeat);
  // Only the final beat can stall: it needs the output slot free or draining this cycle.
  assign bus.in_ready = !bus.restart && !(last_beat && bus.out_valid && !bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign final_fire   = in_fire && last_beat;
  assign term         = bus.in_bit ? bus.in_col : '0;

  always_comb begin
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    if (bus.restart || final_fire) begin
      acc_d      = '0;
      beat_cnt_d = '0;
    end else if (in_fire) begin
      acc_d      = acc_q ^ term;
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  toep_out_buf #(
    .L (L)
  ) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (final_fire),
    .data_i  (acc_q ^ term),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_hash)
  );

  assign bus.beat_cnt = beat_cnt_q;

endmodule
